jtcontra_sndcmd: RTL and testbench

Parametrised main-to-sound command mailbox replacing the single sound latch plus edge-triggered IRQ flip-flop of the sound board. The main CPU pushes command bytes into a DEPTH-entry FIFO (or a single overwrite latch in MODE 0). The sound CPU pops them and receives an interrupt per command. A reply register carries status back from the sound CPU to the main CPU. Sits between the main CPU bus decoder and the sound Z80 `cpu_din` mux / `int_n` input.

---
 rtl/jtcontra_sndcmd_if.sv | 37 +++
 rtl/jtcontra_sndcmd.sv | 118 +++++++++++
 tb/tb_jtcontra_sndcmd.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcontra_sndcmd_if.sv
// Main-to-sound mailbox bus: command push/pop, reply register, IRQ and flush.
// master = the CPU-side decoders driving strobes, slave = the mailbox itself.
interface jtcontra_sndcmd_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          main_we;
    logic [DW-1:0] main_din;
    logic          main_rd;
    logic          main_full;
    logic          main_ovf;
    logic [DW-1:0] main_reply;
    logic          main_rvalid;
    logic          snd_rd;
    logic [DW-1:0] snd_dout;
    logic          snd_empty;
    logic [CW-1:0] snd_count;
    logic          snd_we;
    logic [DW-1:0] snd_din;
    logic          irq_ack;
    logic          snd_irq_n;
    logic          flush;

    modport master (
        output main_we, main_din, main_rd, snd_rd, snd_we, snd_din, irq_ack, flush,
        input  main_full, main_ovf, main_reply, main_rvalid,
               snd_dout, snd_empty, snd_count, snd_irq_n
    );

    modport slave (
        input  main_we, main_din, main_rd, snd_rd, snd_we, snd_din, irq_ack, flush,
        output main_full, main_ovf, main_reply, main_rvalid,
               snd_dout, snd_empty, snd_count, snd_irq_n
    );
endinterface

// File: rtl/jtcontra_sndcmd.sv
// Sound command mailbox: FIFO (or overwrite latch) from main CPU to sound CPU,
// per-command sound IRQ and a reply register back to the main CPU.
module jtcontra_sndcmd #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int MODE      = 1,
    parameter int IRQ_LEVEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    jtcontra_sndcmd_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          push_p1, pop_p1, rrd_p1, rwr_p1, ack_p1;
    logic          ev_push, ev_pop, ev_rrd, ev_rwr, ev_ack;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          ovf, pending, rvalid;
    logic [DW-1:0] latch, reply;
    logic [DW-1:0] mem [DEPTH];
    logic          full, empty, pop_ok, push_ok, drop;

    // Previous-sample registers start high so a strobe held through reset is not an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_p1 <= 1'b1;
            pop_p1  <= 1'b1;
            rrd_p1  <= 1'b1;
            rwr_p1  <= 1'b1;
            ack_p1  <= 1'b1;
        end else begin
            push_p1 <= bus.main_we;
            pop_p1  <= bus.snd_rd;
            rrd_p1  <= bus.main_rd;
            rwr_p1  <= bus.snd_we;
            ack_p1  <= bus.irq_ack;
        end
    end

    assign ev_push = bus.main_we & ~push_p1;
    assign ev_pop  = bus.snd_rd  & ~pop_p1;
    assign ev_rrd  = bus.main_rd & ~rrd_p1;
    assign ev_rwr  = bus.snd_we  & ~rwr_p1;
    assign ev_ack  = bus.irq_ack & ~ack_p1;

    assign full    = (MODE != 0) && (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = ev_pop & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands
    assign push_ok = (MODE == 0) ? ev_push : (ev_push & (~full | pop_ok));
    assign drop    = (MODE != 0) && ev_push && full && !pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            pending <= 1'b0;
            latch   <= '0;
            reply   <= '0;
            rvalid  <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                ovf     <= 1'b0;
                pending <= 1'b0;
            end else begin
                if (MODE == 0) begin
                    if (ev_push) begin
                        latch <= bus.main_din;
                        count <= CW'(1);
                    end else if (ev_pop) begin
                        count <= '0;
                    end
                end else begin
                    if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                    if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                    if (push_ok && !pop_ok)
                        count <= count + 1'b1;
                    else if (pop_ok && !push_ok)
                        count <= count - 1'b1;
                    if (drop) ovf <= 1'b1;
                end
                if (push_ok)
                    pending <= 1'b1;
                else if (ev_ack)
                    pending <= 1'b0;
            end
            // Reply path ignores flush; a same-cycle write beats the read clear
            if (ev_rwr) begin
                reply  <= bus.snd_din;
                rvalid <= 1'b1;
            end else if (ev_rrd) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((MODE != 0) && push_ok && !bus.flush)
            mem[wr_ptr] <= bus.main_din;
    end

    assign bus.main_full   = full;
    assign bus.main_ovf    = ovf;
    assign bus.main_reply  = reply;
    assign bus.main_rvalid = rvalid;
    assign bus.snd_empty   = empty;
    assign bus.snd_count   = count;
    assign bus.snd_dout    = (MODE == 0) ? latch : (empty ? {DW{1'b1}} : mem[rd_ptr]);
    assign bus.snd_irq_n   = (IRQ_LEVEL != 0) ? empty : ~pending;
endmodule

// File: tb/tb_jtcontra_sndcmd.sv
// Bench for jtcontra_sndcmd: FIFO/IRQ0, latch mode and level-IRQ instances driven
// by one stimulus stream and compared to a queue-based model plus a directed table.
`timescale 1ns/1ps
module tb_jtcontra_sndcmd;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtcontra_sndcmd_if #(.DW(8), .DEPTH(DEPTH)) b1 ();
    jtcontra_sndcmd_if #(.DW(8), .DEPTH(DEPTH)) b0 ();
    jtcontra_sndcmd_if #(.DW(8), .DEPTH(DEPTH)) bl ();

    assign b0.main_we  = b1.main_we;
    assign b0.main_din = b1.main_din;
    assign b0.main_rd  = b1.main_rd;
    assign b0.snd_rd   = b1.snd_rd & ~b1.main_we;
    assign b0.snd_we   = b1.snd_we;
    assign b0.snd_din  = b1.snd_din;
    assign b0.irq_ack  = b1.irq_ack;
    assign b0.flush    = b1.flush;
    assign bl.main_we  = b1.main_we;
    assign bl.main_din = b1.main_din;
    assign bl.main_rd  = b1.main_rd;
    assign bl.snd_rd   = b1.snd_rd;
    assign bl.snd_we   = b1.snd_we;
    assign bl.snd_din  = b1.snd_din;
    assign bl.irq_ack  = b1.irq_ack;
    assign bl.flush    = b1.flush;

    jtcontra_sndcmd #(.DW(8), .DEPTH(DEPTH), .MODE(1), .IRQ_LEVEL(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    jtcontra_sndcmd #(.DW(8), .DEPTH(DEPTH), .MODE(0), .IRQ_LEVEL(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    jtcontra_sndcmd #(.DW(8), .DEPTH(DEPTH), .MODE(1), .IRQ_LEVEL(1)) dutl (.clk(clk), .rst_n(rst_n), .bus(bl));

    int total = 0;
    int bad = 0;

    byte unsigned q[$];
    bit           m_ovf, m_pend, m_pend0, m_rvalid;
    byte unsigned m_latch, m_reply;
    int           m_cnt0;

    typedef struct {
        bit we, rd, swe, mrd, ack, fl;
        logic [7:0] din, sdin, dout;
        int cnt;
        bit full, ovf, irqn;
        logic [7:0] reply;
        bit rv;
    } vec_t;
    vec_t tbl[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_pend = 0; m_pend0 = 0; m_rvalid = 0;
        m_latch = 0; m_reply = 0; m_cnt0 = 0;
    endtask

    task automatic model_op(input bit we, input byte unsigned din, input bit rd, input bit swe,
                            input byte unsigned sdin, input bit mrd, input bit ack, input bit fl);
        bit acc;
        if (fl) begin
            q.delete();
            m_ovf = 0; m_pend = 0; m_cnt0 = 0; m_pend0 = 0;
        end else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            acc = 0;
            if (we) begin
                if (q.size() < DEPTH) begin q.push_back(din); acc = 1; end
                else m_ovf = 1;
            end
            if (acc) m_pend = 1; else if (ack) m_pend = 0;
            if (we) begin
                m_latch = din; m_cnt0 = 1; m_pend0 = 1;
            end else begin
                if (rd) m_cnt0 = 0;
                if (ack) m_pend0 = 0;
            end
        end
        if (swe) begin m_reply = sdin; m_rvalid = 1; end
        else if (mrd) m_rvalid = 0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("m1_dout",   b1.snd_dout,    (n > 0) ? q[0] : 8'hFF);
        chk("m1_count",  b1.snd_count,   n);
        chk("m1_empty",  b1.snd_empty,   n == 0);
        chk("m1_full",   b1.main_full,   n == DEPTH);
        chk("m1_ovf",    b1.main_ovf,    m_ovf);
        chk("m1_irqn",   b1.snd_irq_n,   !m_pend);
        chk("m1_reply",  b1.main_reply,  m_reply);
        chk("m1_rvalid", b1.main_rvalid, m_rvalid);
        chk("m0_dout",   b0.snd_dout,    m_latch);
        chk("m0_count",  b0.snd_count,   m_cnt0);
        chk("m0_empty",  b0.snd_empty,   m_cnt0 == 0);
        chk("m0_full",   b0.main_full,   0);
        chk("m0_ovf",    b0.main_ovf,    0);
        chk("m0_irqn",   b0.snd_irq_n,   !m_pend0);
        chk("lvl_count", bl.snd_count,   n);
        chk("lvl_irqn",  bl.snd_irq_n,   n == 0);
    endtask

    // One event: strobes high for one sampled cycle, low for the next; called at a negedge
    task automatic op(input bit we, input byte unsigned din, input bit rd, input bit swe,
                      input byte unsigned sdin, input bit mrd, input bit ack, input bit fl);
        b1.main_we = we; b1.main_din = din; b1.snd_rd = rd; b1.snd_we = swe;
        b1.snd_din = sdin; b1.main_rd = mrd; b1.irq_ack = ack; b1.flush = fl;
        @(negedge clk);
        b1.main_we = 0; b1.snd_rd = 0; b1.snd_we = 0; b1.main_rd = 0; b1.irq_ack = 0; b1.flush = 0;
        @(negedge clk);
        model_op(we, din, rd, swe, sdin, mrd, ack, fl);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_m1_dout"},  b1.snd_dout,    8'hFF);
        chk({tag, "_m0_dout"},  b0.snd_dout,    8'h00);
        chk({tag, "_count"},    b1.snd_count,   0);
        chk({tag, "_empty"},    b1.snd_empty,   1);
        chk({tag, "_full"},     b1.main_full,   0);
        chk({tag, "_ovf"},      b1.main_ovf,    0);
        chk({tag, "_irqn"},     b1.snd_irq_n,   1);
        chk({tag, "_lvl_irqn"}, bl.snd_irq_n,   1);
        chk({tag, "_reply"},    b1.main_reply,  8'h00);
        chk({tag, "_rvalid"},   b1.main_rvalid, 0);
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,0,0, 8'h11,8'h00, 8'h11,1,0,0,0, 8'h00,0};
        tbl[1]  = '{1,0,0,0,0,0, 8'h22,8'h00, 8'h11,2,0,0,0, 8'h00,0};
        tbl[2]  = '{1,0,0,0,0,0, 8'h33,8'h00, 8'h11,3,0,0,0, 8'h00,0};
        tbl[3]  = '{0,1,0,0,0,0, 8'h00,8'h00, 8'h22,2,0,0,0, 8'h00,0};
        tbl[4]  = '{0,1,0,0,0,0, 8'h00,8'h00, 8'h33,1,0,0,0, 8'h00,0};
        tbl[5]  = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hFF,0,0,0,0, 8'h00,0};
        tbl[6]  = '{0,0,0,0,1,0, 8'h00,8'h00, 8'hFF,0,0,0,1, 8'h00,0};
        tbl[7]  = '{1,0,0,0,0,0, 8'h01,8'h00, 8'h01,1,0,0,0, 8'h00,0};
        tbl[8]  = '{1,0,0,0,0,0, 8'h02,8'h00, 8'h01,2,0,0,0, 8'h00,0};
        tbl[9]  = '{1,0,0,0,0,0, 8'h03,8'h00, 8'h01,3,0,0,0, 8'h00,0};
        tbl[10] = '{1,0,0,0,0,0, 8'h04,8'h00, 8'h01,4,1,0,0, 8'h00,0};
        tbl[11] = '{1,0,0,0,0,0, 8'h05,8'h00, 8'h01,4,1,1,0, 8'h00,0};
        tbl[12] = '{0,0,0,0,0,1, 8'h00,8'h00, 8'hFF,0,0,0,1, 8'h00,0};
        tbl[13] = '{1,0,0,0,0,0, 8'hA1,8'h00, 8'hA1,1,0,0,0, 8'h00,0};
        tbl[14] = '{1,0,0,0,0,0, 8'hA2,8'h00, 8'hA1,2,0,0,0, 8'h00,0};
        tbl[15] = '{1,0,0,0,0,0, 8'hA3,8'h00, 8'hA1,3,0,0,0, 8'h00,0};
        tbl[16] = '{1,0,0,0,0,0, 8'hA4,8'h00, 8'hA1,4,1,0,0, 8'h00,0};
        tbl[17] = '{1,1,0,0,0,0, 8'hB5,8'h00, 8'hA2,4,1,0,0, 8'h00,0};
        tbl[18] = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hA3,3,0,0,0, 8'h00,0};
        tbl[19] = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hA4,2,0,0,0, 8'h00,0};
        tbl[20] = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hB5,1,0,0,0, 8'h00,0};
        tbl[21] = '{0,0,0,0,1,0, 8'h00,8'h00, 8'hB5,1,0,0,1, 8'h00,0};
        tbl[22] = '{1,0,0,0,1,0, 8'hC6,8'h00, 8'hB5,2,0,0,0, 8'h00,0};
        tbl[23] = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hC6,1,0,0,0, 8'h00,0};
        tbl[24] = '{0,0,0,0,1,0, 8'h00,8'h00, 8'hC6,1,0,0,1, 8'h00,0};
        tbl[25] = '{0,0,1,0,0,0, 8'h00,8'h3C, 8'hC6,1,0,0,1, 8'h3C,1};
        tbl[26] = '{0,0,0,1,0,0, 8'h00,8'h00, 8'hC6,1,0,0,1, 8'h3C,0};
        tbl[27] = '{0,0,1,1,0,0, 8'h00,8'h77, 8'hC6,1,0,0,1, 8'h77,1};
        tbl[28] = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hFF,0,0,0,1, 8'h77,1};
        tbl[29] = '{0,1,0,0,0,0, 8'h00,8'h00, 8'hFF,0,0,0,1, 8'h77,1};
        tbl[30] = '{1,1,0,0,0,0, 8'hD7,8'h00, 8'hD7,1,0,0,0, 8'h77,1};
        tbl[31] = '{1,0,0,0,0,1, 8'hE8,8'h00, 8'hFF,0,0,0,1, 8'h77,1};

        b1.main_we = 1; b1.main_din = 8'h66; b1.snd_rd = 0; b1.snd_we = 0;
        b1.snd_din = 0; b1.main_rd = 0; b1.irq_ack = 0; b1.flush = 0;
        model_reset();

        // Reset state with main_we held high across release
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1;
        repeat (3) @(negedge clk);
        b1.main_we = 0;
        repeat (2) @(negedge clk);
        check_all();

        // A six-cycle-long write is one push
        b1.main_din = 8'h99; b1.main_we = 1;
        repeat (6) @(negedge clk);
        b1.main_we = 0;
        repeat (2) @(negedge clk);
        model_op(1, 8'h99, 0, 0, 0, 0, 0, 0);
        check_all();
        op(0, 0, 0, 0, 0, 0, 0, 1);
        check_all();

        for (int i = 0; i < 32; i++) begin
            op(tbl[i].we, tbl[i].din, tbl[i].rd, tbl[i].swe, tbl[i].sdin, tbl[i].mrd, tbl[i].ack, tbl[i].fl);
            chk($sformatf("tbl%0d_dout", i),   b1.snd_dout,    tbl[i].dout);
            chk($sformatf("tbl%0d_count", i),  b1.snd_count,   tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i),   b1.main_full,   tbl[i].full);
            chk($sformatf("tbl%0d_ovf", i),    b1.main_ovf,    tbl[i].ovf);
            chk($sformatf("tbl%0d_irqn", i),   b1.snd_irq_n,   tbl[i].irqn);
            chk($sformatf("tbl%0d_reply", i),  b1.main_reply,  tbl[i].reply);
            chk($sformatf("tbl%0d_rvalid", i), b1.main_rvalid, tbl[i].rv);
            check_all();
        end

        // Latch mode: overwrite, then pop keeps the last value visible
        op(1, 8'hA5, 0, 0, 0, 0, 0, 0);
        op(1, 8'h5A, 0, 0, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0, 0, 0, 0);
        chk("m0seq_dout",  b0.snd_dout,  8'h5A);
        chk("m0seq_count", b0.snd_count, 0);
        chk("m0seq_empty", b0.snd_empty, 1);
        chk("m0seq_ovf",   b0.main_ovf,  0);
        op(0, 0, 0, 0, 0, 0, 0, 0);
        chk("m0seq_hold",  b0.snd_dout,  8'h5A);
        check_all();

        // Asynchronous reset in the middle of traffic
        op(1, 8'h12, 0, 0, 0, 0, 0, 0);
        op(1, 8'h34, 0, 1, 8'h56, 0, 0, 0);
        check_all();
        #2 rst_n = 0;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check_all();

        for (int i = 0; i < 400; i++) begin
            op(($urandom % 3) == 0, 8'($urandom), ($urandom % 3) == 0, ($urandom % 6) == 0,
               8'($urandom), ($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 25) == 0);
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
